// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial transmit arbiter.
package serial_pkg;

  localparam int CHAR_W = 8;

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} arb_state_t;

  // Round-robin pointer increment for a pointer that wraps at n.
  function automatic int next_rr(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/serial_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = |req;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(rr_ptr) + off) % N]) begin
        win     = N'(1) << ((int'(rr_ptr) + off) % N);
        win_idx = IW'((int'(rr_ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between NUM_REQ byte sources.
// Optional WAIT watchdog and sticky timeout_err port enabled by SERIAL_ARB_TIMEOUT_EN.
module serial_tx_arbiter
  import serial_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CHAR_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_start,
  output logic [CHAR_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      busy,
`ifdef SERIAL_ARB_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output arb_state_t                dbg_state
);

  // Handshake: req[i] is a level held until its one-cycle grant[i]; the grant is the accept strobe.
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_t          r_state, w_state_nx;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nx;
  logic                r_tx_start, w_tx_start_nx;
  logic [CHAR_W-1:0]   r_tx_data, w_tx_data_nx;
  logic                r_busy;
  logic [IW-1:0]       r_rr_ptr, w_rr_nx;
  logic [IW-1:0]       r_win_idx, w_win_idx_nx;
  logic [GW-1:0]       r_gap_cnt, w_gap_nx;
  logic [NUM_REQ-1:0]  w_win;
  logic [IW-1:0]       w_pick_idx;
  logic                w_any;
`ifdef SERIAL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]       r_to_cnt, w_to_nx;
  logic                r_timeout_err, w_err_nx;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .win     (w_win),
    .win_idx (w_pick_idx),
    .any     (w_any)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_grant_nx    = '0;
    w_tx_start_nx = 1'b0;
    w_tx_data_nx  = r_tx_data;
    w_rr_nx       = r_rr_ptr;
    w_win_idx_nx  = r_win_idx;
    w_gap_nx      = r_gap_cnt;
`ifdef SERIAL_ARB_TIMEOUT_EN
    w_to_nx       = r_to_cnt;
    w_err_nx      = r_timeout_err;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nx    = START;
          w_grant_nx    = w_win;
          w_tx_start_nx = 1'b1;
          w_win_idx_nx  = w_pick_idx;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) w_tx_data_nx = req_data[i*CHAR_W +: CHAR_W];
          end
        end
      end
      START: begin
        w_rr_nx    = IW'(next_rr(int'(r_win_idx), NUM_REQ));
        w_state_nx = WAIT;
`ifdef SERIAL_ARB_TIMEOUT_EN
        // One clock has already elapsed since tx_start when WAIT is entered.
        w_to_nx    = TW'(1);
`endif
      end
      WAIT: begin
        if (tx_done) begin
          if (GAP_CYCLES == 0) begin
            w_state_nx = IDLE;
          end else begin
            w_state_nx = GAP;
            w_gap_nx   = GW'(GAP_CYCLES - 1);
          end
        end
`ifdef SERIAL_ARB_TIMEOUT_EN
        else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_state_nx = IDLE;
          w_err_nx   = 1'b1;
        end else begin
          w_to_nx = r_to_cnt + TW'(1);
        end
`endif
      end
      GAP: begin
        if (r_gap_cnt == '0) w_state_nx = IDLE;
        else                 w_gap_nx   = r_gap_cnt - GW'(1);
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_grant       <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_busy        <= 1'b0;
      r_rr_ptr      <= '0;
      r_win_idx     <= '0;
      r_gap_cnt     <= '0;
`ifdef SERIAL_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nx;
      r_grant       <= w_grant_nx;
      r_tx_start    <= w_tx_start_nx;
      r_tx_data     <= w_tx_data_nx;
      r_busy        <= (w_state_nx != IDLE);
      r_rr_ptr      <= w_rr_nx;
      r_win_idx     <= w_win_idx_nx;
      r_gap_cnt     <= w_gap_nx;
`ifdef SERIAL_ARB_TIMEOUT_EN
      r_to_cnt      <= w_to_nx;
      r_timeout_err <= w_err_nx;
`endif
    end
  end

  assign grant     = r_grant;
  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign busy      = r_busy;
  assign dbg_state = r_state;
`ifdef SERIAL_ARB_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`endif

endmodule
